// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helper, default geometry and status bundle for the
// programmable synchronous FIFO family.
package fifo_pkg;
   localparam int FIFO_WIDTH_DEF = 16;
   localparam int FIFO_DEPTH_DEF = 8;

   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
      logic wr_ack;
      logic overflow;
      logic underflow;
   } fifo_status_t;
endpackage

// File: rtl/fifo_prog_if.sv
// fifo_prog_if: bundle of every fifo_sync_prog signal with modports for the
// design, a driving test and a passive monitor.
interface fifo_prog_if import fifo_pkg::*; #(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input logic clk
);
   localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);
   logic rst_n, wr_en, rd_en, flush;
   logic full, empty, almostfull, almostempty, wr_ack, overflow, underflow;
   logic [FIFO_WIDTH-1:0] data_in, data_out;
   logic [CNT_W-1:0] af_thresh, ae_thresh, count;

   modport DUT (
      input clk, rst_n, data_in, wr_en, rd_en, flush, af_thresh, ae_thresh,
      output data_out, count, full, empty, almostfull, almostempty, wr_ack, overflow, underflow
   );
   modport TEST (
      input clk, data_out, count, full, empty, almostfull, almostempty, wr_ack, overflow, underflow,
      output rst_n, data_in, wr_en, rd_en, flush, af_thresh, ae_thresh
   );
   modport MONITOR (
      input clk, rst_n, data_in, wr_en, rd_en, flush, af_thresh, ae_thresh,
      data_out, count, full, empty, almostfull, almostempty, wr_ack, overflow, underflow
   );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: storage array with one synchronous write port and one
// asynchronous read port; contents are never reset.
module fifo_mem import fifo_pkg::*; #(
   parameter int WIDTH = FIFO_WIDTH_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with fill level, programmable almost
// thresholds, synchronous flush and optional first-word fall-through.
module fifo_sync_prog import fifo_pkg::*; #(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int FWFT = 0,
   localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  flush,
   input  logic [CNT_W-1:0]      af_thresh,
   input  logic [CNT_W-1:0]      ae_thresh,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_WIDTH-1:0] rd_data, dout_q;
   logic wr_ok, rd_ok;

   assign full        = count == CNT_W'(FIFO_DEPTH);
   assign empty       = count == '0;
   assign almostfull  = (count >= af_thresh) && !full;
   assign almostempty = (count <= ae_thresh) && !empty;
   assign wr_ok       = wr_en && !full;
   assign rd_ok       = rd_en && !empty;

   // flush wins over a same-cycle write, so the array is left untouched too
   fifo_mem #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) u_mem (
      .clk   (clk),
      .we    (wr_ok && !flush),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         dout_q    <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         if (wr_ok != rd_ok) count <= wr_ok ? count + 1'b1 : count - 1'b1;
         if (rd_ok) dout_q <= rd_data;
         wr_ack    <= wr_ok;
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end

   assign data_out = (FWFT != 0) ? (empty ? '0 : rd_data) : dout_q;
endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb_fifo_sync_prog: directed and random checks of registered and FWFT
// instances against a queue-based reference model.
module tb_fifo_sync_prog;
   import fifo_pkg::*;

   logic clk = 1'b0, rst_n = 1'b1, wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0] af_thresh = 4'd6, ae_thresh = 4'd2;
   logic [15:0] data_out, f_data_out;
   logic [3:0] count, f_count;
   logic full, empty, almostfull, almostempty, wr_ack, overflow, underflow;
   logic f_full, f_empty, f_af, f_ae, f_ack, f_ovf, f_udf;

   int checks = 0, passes = 0;
   logic [15:0] q[$];
   logic [15:0] m_dout = '0;
   logic m_ack = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

   always #5 clk = ~clk;

   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(data_out), .count(count),
      .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
      .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow)
   );

   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(f_data_out), .count(f_count),
      .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae),
      .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_udf)
   );

   function automatic fifo_status_t exp_status();
      int n = q.size();
      fifo_status_t s;
      s.full        = n == 8;
      s.empty       = n == 0;
      s.almostfull  = n >= int'(af_thresh) && n < 8;
      s.almostempty = n <= int'(ae_thresh) && n > 0;
      s.wr_ack      = m_ack;
      s.overflow    = m_ovf;
      s.underflow   = m_udf;
      return s;
   endfunction

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_ack = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   // one clock of stimulus; the model applies the same request to its queue
   task automatic cycle(input logic w, input logic r, input logic f, input logic [15:0] d);
      int n;
      wr_en = w; rd_en = r; flush = f; data_in = d;
      @(posedge clk);
      n = q.size();
      if (f) begin
         q.delete();
         m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         m_ack = w && n < 8;
         m_ovf = w && n == 8;
         m_udf = r && n == 0;
         if (r && n > 0) m_dout = q.pop_front();
         if (w && n < 8) q.push_back(d);
      end
      #1;
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #10;
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      checks++; if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else passes++;
      checks++; if ({full, empty, almostfull, almostempty, wr_ack, overflow, underflow} !== 7'b0100000)
         $display("FAIL reset_flags got %b want 0100000", {full, empty, almostfull, almostempty, wr_ack, overflow, underflow}); else passes++;
      checks++; if (data_out !== 16'h0) $display("FAIL reset_dout got %h want 0000", data_out); else passes++;
      checks++; if (f_data_out !== 16'h0) $display("FAIL reset_fwft_dout got %h want 0000", f_data_out); else passes++;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 16'(i));
         checks++; if (count !== 4'(i)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); else passes++;
         checks++; if (wr_ack !== 1'b1) $display("FAIL fill_ack[%0d] got %b want 1", i, wr_ack); else passes++;
         checks++; if (almostempty !== (i <= 2)) $display("FAIL fill_ae[%0d] got %b want %b", i, almostempty, i <= 2); else passes++;
         checks++; if (almostfull !== (i >= 6 && i < 8)) $display("FAIL fill_af[%0d] got %b want %b", i, almostfull, i >= 6 && i < 8); else passes++;
         checks++; if (full !== (i == 8)) $display("FAIL fill_full[%0d] got %b want %b", i, full, i == 8); else passes++;
      end
      cycle(1'b1, 1'b0, 1'b0, 16'h0009);
      checks++; if (overflow !== 1'b1) $display("FAIL overflow got %b want 1", overflow); else passes++;
      checks++; if (wr_ack !== 1'b0) $display("FAIL overflow_ack got %b want 0", wr_ack); else passes++;
      checks++; if (count !== 4'd8) $display("FAIL overflow_count got %0d want 8", count); else passes++;
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 16'h0);
         checks++; if (data_out !== 16'(i)) $display("FAIL drain_dout[%0d] got %h want %h", i, data_out, 16'(i)); else passes++;
         checks++; if (count !== 4'(8 - i)) $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 8 - i); else passes++;
         checks++; if (empty !== (i == 8)) $display("FAIL drain_empty[%0d] got %b want %b", i, empty, i == 8); else passes++;
      end
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      checks++; if (underflow !== 1'b1) $display("FAIL underflow got %b want 1", underflow); else passes++;
      checks++; if (data_out !== 16'h0008) $display("FAIL underflow_dout got %h want 0008", data_out); else passes++;
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0010 + 16'(i));
      cycle(1'b1, 1'b1, 1'b0, 16'h0014);
      checks++; if (count !== 4'd4) $display("FAIL both4_count got %0d want 4", count); else passes++;
      checks++; if (wr_ack !== 1'b1) $display("FAIL both4_ack got %b want 1", wr_ack); else passes++;
      checks++; if (data_out !== 16'h0010) $display("FAIL both4_dout got %h want 0010", data_out); else passes++;
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
      cycle(1'b1, 1'b1, 1'b0, 16'h0020);
      checks++; if (underflow !== 1'b1) $display("FAIL both0_udf got %b want 1", underflow); else passes++;
      checks++; if (wr_ack !== 1'b1) $display("FAIL both0_ack got %b want 1", wr_ack); else passes++;
      checks++; if (count !== 4'd1) $display("FAIL both0_count got %0d want 1", count); else passes++;
      for (int i = 1; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0020 + 16'(i));
      cycle(1'b1, 1'b1, 1'b0, 16'h0030);
      checks++; if (overflow !== 1'b1) $display("FAIL both8_ovf got %b want 1", overflow); else passes++;
      checks++; if (count !== 4'd7) $display("FAIL both8_count got %0d want 7", count); else passes++;
      checks++; if (data_out !== 16'h0020) $display("FAIL both8_dout got %h want 0020", data_out); else passes++;
   endtask

   task automatic test_random();
      int wprob;
      cycle(1'b0, 1'b0, 1'b1, 16'h0);
      for (int k = 0; k < 1000; k++) begin
         if (k % 100 == 0) begin
            af_thresh = 4'($urandom_range(1, 7));
            ae_thresh = 4'($urandom_range(1, 7));
         end
         wprob = ((k / 100) % 2 == 0) ? 70 : 30;
         cycle($urandom_range(0, 99) < wprob, $urandom_range(0, 99) >= wprob, 1'b0, 16'($urandom));
         checks++; if (count !== 4'(q.size())) $display("FAIL rand_count[%0d] got %0d want %0d", k, count, q.size()); else passes++;
         checks++; if ({full, empty, almostfull, almostempty, wr_ack, overflow, underflow} !== exp_status())
            $display("FAIL rand_flags[%0d] got %b want %b", k, {full, empty, almostfull, almostempty, wr_ack, overflow, underflow}, exp_status()); else passes++;
         checks++; if (data_out !== m_dout) $display("FAIL rand_dout[%0d] got %h want %h", k, data_out, m_dout); else passes++;
         checks++; if (f_data_out !== (q.size() > 0 ? q[0] : 16'h0))
            $display("FAIL rand_fwft_dout[%0d] got %h want %h", k, f_data_out, q.size() > 0 ? q[0] : 16'h0); else passes++;
         checks++; if (f_count !== 4'(q.size())) $display("FAIL rand_fwft_count[%0d] got %0d want %0d", k, f_count, q.size()); else passes++;
      end
      af_thresh = 4'd6;
      ae_thresh = 4'd2;
   endtask

   task automatic test_fwft();
      cycle(1'b0, 1'b0, 1'b1, 16'h0);
      cycle(1'b1, 1'b0, 1'b0, 16'hBEEF);
      checks++; if (f_data_out !== 16'hBEEF) $display("FAIL fwft_head got %h want beef", f_data_out); else passes++;
      checks++; if (f_empty !== 1'b0) $display("FAIL fwft_not_empty got %b want 0", f_empty); else passes++;
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      checks++; if (f_empty !== 1'b1) $display("FAIL fwft_empty got %b want 1", f_empty); else passes++;
      checks++; if (f_data_out !== 16'h0) $display("FAIL fwft_empty_dout got %h want 0000", f_data_out); else passes++;
      checks++; if (data_out !== 16'hBEEF) $display("FAIL reg_beef got %h want beef", data_out); else passes++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0040 + 16'(i));
      cycle(1'b1, 1'b0, 1'b1, 16'h0055);
      checks++; if (count !== 4'd0) $display("FAIL flush_count got %0d want 0", count); else passes++;
      checks++; if (empty !== 1'b1) $display("FAIL flush_empty got %b want 1", empty); else passes++;
      checks++; if (wr_ack !== 1'b0) $display("FAIL flush_ack got %b want 0", wr_ack); else passes++;
      checks++; if (data_out !== 16'hBEEF) $display("FAIL flush_dout got %h want beef", data_out); else passes++;
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      checks++; if (underflow !== 1'b1) $display("FAIL flush_udf got %b want 1", underflow); else passes++;
   endtask

   task automatic test_reset_mid();
      for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h00A0 + 16'(i));
      wr_en = 1'b1;
      data_in = 16'h00A4;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (count !== 4'd0) $display("FAIL rstmid_count got %0d want 0", count); else passes++;
      checks++; if ({full, empty, almostfull, almostempty, wr_ack, overflow, underflow} !== 7'b0100000)
         $display("FAIL rstmid_flags got %b want 0100000", {full, empty, almostfull, almostempty, wr_ack, overflow, underflow}); else passes++;
      checks++; if (data_out !== 16'h0) $display("FAIL rstmid_dout got %h want 0000", data_out); else passes++;
      checks++; if (f_data_out !== 16'h0) $display("FAIL rstmid_fwft_dout got %h want 0000", f_data_out); else passes++;
      wr_en = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      cycle(1'b1, 1'b0, 1'b0, 16'h00C1);
      checks++; if (count !== 4'd1) $display("FAIL rel_count got %0d want 1", count); else passes++;
      checks++; if (wr_ack !== 1'b1) $display("FAIL rel_ack got %b want 1", wr_ack); else passes++;
      checks++; if (f_data_out !== 16'h00C1) $display("FAIL rel_fwft_dout got %h want 00c1", f_data_out); else passes++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_random();
      test_fwft();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
